// File: rtl/apple_gen_if.sv
// Snake-controller side of the apple generator: game state and head position
// in, growth request, apple position and score out.
interface apple_gen_if;
    logic [2:0] Game_status;
    logic [5:0] Head_x;
    logic [5:0] Head_y;
    logic       Body_add_sig;
    logic [5:0] Apple_x;
    logic [5:0] Apple_y;
    logic       Apple_valid;
    logic [3:0] Score;

    // Snake controller / game logic drives the head and game state
    modport master (
        output Game_status, Head_x, Head_y,
        input  Body_add_sig, Apple_x, Apple_y, Apple_valid, Score
    );

    // Apple generator consumes the head and game state
    modport slave (
        input  Game_status, Head_x, Head_y,
        output Body_add_sig, Apple_x, Apple_y, Apple_valid, Score
    );
endinterface

// File: rtl/apple_gen.sv
// Apple (food) generator for the Snake game: places an apple on a random
// playfield cell, detects the head eating it, requests one segment of growth
// as a held level, keeps a saturating score and flags the apple pixel for VGA.
module apple_gen #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned MAX_SCORE   = 13
) (
    input  logic       Clk_50mhz,
    input  logic       Rst_n,
    apple_gen_if.slave game,
    input  logic [9:0] Pixel_x,
    input  logic [9:0] Pixel_y,
    output logic       Apple_pix
);

    typedef enum logic [1:0] {
        PLACE,
        ACTIVE,
        EATEN
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [15:0] lfsr;
    logic [5:0]  apple_x;
    logic [5:0]  apple_y;
    logic        apple_valid;
    logic        body_add;
    logic [3:0]  score;
    logic [7:0]  hold_cnt;

    logic [5:0]  cand_x;
    logic [5:0]  cand_y;
    logic        cand_ok;
    logic        st_play;
    logic        st_end;
    logic        head_hit;
    logic        do_place;
    logic        do_eat;
    logic        do_release;

    // Non-one-hot codes decode as neither PLAY nor END, i.e. behave as START
    assign st_play  = (game.Game_status == 3'b010);
    assign st_end   = (game.Game_status == 3'b100);

    assign cand_x   = lfsr[5:0];
    assign cand_y   = {1'b0, lfsr[12:8]};
    assign cand_ok  = (cand_x >= 6'd1) && (cand_x <= 6'd38) &&
                      (cand_y >= 6'd1) && (cand_y <= 6'd28) &&
                      !((cand_x == game.Head_x) && (cand_y == game.Head_y));
    assign head_hit = (game.Head_x == apple_x) && (game.Head_y == apple_y);

    // Free-running Fibonacci LFSR, taps 16,14,13,11; non-zero seed keeps it off zero
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // FSM state register
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= PLACE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode; END overrides every state
    always_comb begin
        state_n    = state;
        do_place   = 1'b0;
        do_eat     = 1'b0;
        do_release = 1'b0;
        if (st_end) begin
            state_n = PLACE;
        end else begin
            case (state)
                PLACE: begin
                    if (cand_ok) begin
                        state_n  = ACTIVE;
                        do_place = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (st_play && head_hit) begin
                        state_n = EATEN;
                        do_eat  = 1'b1;
                    end
                end
                EATEN: begin
                    if (hold_cnt == '0) begin
                        state_n    = PLACE;
                        do_release = 1'b1;
                    end
                end
                default: state_n = PLACE;
            endcase
        end
    end

    // Apple position, growth request, hold counter and score
    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            apple_x     <= '0;
            apple_y     <= '0;
            apple_valid <= 1'b0;
            body_add    <= 1'b0;
            score       <= '0;
            hold_cnt    <= '0;
        end else if (st_end) begin
            apple_valid <= 1'b0;
            body_add    <= 1'b0;
            score       <= '0;
        end else begin
            if (do_place) begin
                apple_x     <= cand_x;
                apple_y     <= cand_y;
                apple_valid <= 1'b1;
            end
            if (do_eat) begin
                body_add    <= 1'b1;
                apple_valid <= 1'b0;
                hold_cnt    <= 8'(HOLD_CYCLES - 1);
                score       <= (score < 4'(MAX_SCORE)) ? score + 4'd1 : 4'(MAX_SCORE);
            end
            if (do_release) begin
                body_add <= 1'b0;
            end else if (state == EATEN) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    assign game.Apple_x      = apple_x;
    assign game.Apple_y      = apple_y;
    assign game.Apple_valid  = apple_valid;
    assign game.Body_add_sig = body_add;
    assign game.Score        = score;

    // 16x16 pixel cells; the visible-area bounds keep blanking from aliasing onto the grid
    assign Apple_pix = apple_valid &&
                       (Pixel_x < 10'd640) && (Pixel_y < 10'd480) &&
                       (Pixel_x[9:4] == apple_x) && (Pixel_y[9:4] == apple_y);

endmodule
